// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NUM_REQ requesters.
// Optional `ALU_ARB_LOCK_EN adds req_lock so a granted requester can keep priority.
//
// state | meaning
// IDLE  | searching for a requester; req_ready asserted combinationally on grant
// EXEC  | operands registered onto the ALU; result captured at the end of the cycle
// RESP  | resp_valid held to the owner until its resp_ready
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]      req_op,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_eq,
  output logic [PTR_W-1:0]          resp_id,
  output logic [DATA_W-1:0]         alu_in1,
  output logic [DATA_W-1:0]         alu_in2,
  output logic [3:0]                alu_con,
  input  logic [DATA_W-1:0]         alu_out,
  input  logic                      alu_eq,
  output logic                      busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    resp_id_q, resp_id_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_eq_q, resp_eq_d;
  logic [DATA_W-1:0]   alu_in1_q, alu_in1_d;
  logic [DATA_W-1:0]   alu_in2_q, alu_in2_d;
  logic [3:0]          alu_con_q, alu_con_d;

  logic                grant_found;
  logic [PTR_W-1:0]    grant_idx;

  // (base + off) mod NUM_REQ without a divider; off is always < NUM_REQ
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W+1)'(off);
    if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
    return sum[PTR_W-1:0];
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[wrap_add(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    resp_eq_d   = resp_eq_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    alu_con_d   = alu_con_q;
    req_ready   = '0;
    resp_valid  = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          alu_in1_d = req_a[int'(grant_idx)*DATA_W +: DATA_W];
          alu_in2_d = req_b[int'(grant_idx)*DATA_W +: DATA_W];
          alu_con_d = req_op[int'(grant_idx)*4 +: 4];
          resp_id_d = grant_idx;
          rr_ptr_d  = wrap_add(grant_idx, 1);
`ifdef ALU_ARB_LOCK_EN
          if (req_lock[grant_idx]) rr_ptr_d = grant_idx;
`endif
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        resp_data_d = alu_out;
        resp_eq_d   = alu_eq;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        resp_valid[resp_id_q] = 1'b1;
        if (resp_ready[resp_id_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      resp_eq_q   <= 1'b0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_con_q   <= 4'b0000;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
      resp_eq_q   <= resp_eq_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      alu_con_q   <= alu_con_d;
    end
  end

  assign resp_data = resp_data_q;
  assign resp_eq   = resp_eq_q;
  assign resp_id   = resp_id_q;
  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign alu_con   = alu_con_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with a behavioural ALU and arbitration model.
// Define ALU_ARB_LOCK_EN for both RTL and bench to exercise the priority-lock sequence.
module tb_alu_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int PW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N*4-1:0] req_op;
  logic [W-1:0]   resp_data, alu_in1, alu_in2, alu_out;
  logic           resp_eq, alu_eq, busy;
  logic [PW-1:0]  resp_id;
  logic [3:0]     alu_con;
`ifdef ALU_ARB_LOCK_EN
  logic [N-1:0]   req_lock;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
`ifdef ALU_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_eq(resp_eq), .resp_id(resp_id),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_con(alu_con),
    .alu_out(alu_out), .alu_eq(alu_eq), .busy(busy)
  );

  // ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, others yield 0
  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      default: return '0;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_in1, alu_in2, alu_con);
  assign alu_eq  = (alu_in1 == alu_in2);

  int n_chk = 0;
  int n_fail = 0;
  int rr_m = 0;
  logic [W-1:0] a_m[N];
  logic [W-1:0] b_m[N];
  logic [3:0]   op_m[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0 && i < N) r[i] = 1'b1;
    return r;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_m[i];
      req_b[i*W +: W] = b_m[i];
      req_op[i*4 +: 4] = op_m[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_eq", resp_eq, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_alu_in1", alu_in1, 0);
    check("rst_alu_in2", alu_in2, 0);
    check("rst_alu_con", alu_con, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    rr_m = 0;
  endtask

  task automatic idle_cycles(input int n);
    req_valid = '0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check("idle_req_ready", req_ready, 0);
      check("idle_busy", busy, 0);
      check("idle_resp_valid", resp_valid, 0);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
  task automatic run_txn(input logic [N-1:0] vmask, input bit keep, input int stall,
                         input bit noisy, output int g_act, output logic [W-1:0] d_act,
                         output logic eq_act);
    int eg;
    logic [W-1:0] ed;
    logic eeq;
    logic [N-1:0] nz;
    req_valid = vmask;
    #1;
    eg = pick(rr_m, vmask);
    check("grant_ready", req_ready, onehot(eg));
    check("idle_busy", busy, 0);
    g_act = -1;
    for (int i = N-1; i >= 0; i--) if (req_ready[i]) g_act = i;
    ed  = alu_ref(a_m[eg], b_m[eg], op_m[eg]);
    eeq = (a_m[eg] == b_m[eg]);
    @(posedge clk);
    #1;
`ifdef ALU_ARB_LOCK_EN
    rr_m = req_lock[eg] ? eg : (eg + 1) % N;
`else
    rr_m = (eg + 1) % N;
`endif
    if (!keep) req_valid[eg] = 1'b0;
    @(negedge clk);
    check("exec_busy", busy, 1);
    check("exec_req_ready", req_ready, 0);
    check("exec_resp_valid", resp_valid, 0);
    check("exec_alu_in1", alu_in1, a_m[eg]);
    check("exec_alu_in2", alu_in2, b_m[eg]);
    check("exec_alu_con", alu_con, op_m[eg]);
    @(posedge clk);
    @(negedge clk);
    check("resp_valid", resp_valid, onehot(eg));
    check("resp_data", resp_data, ed);
    check("resp_eq", resp_eq, eeq);
    check("resp_id", resp_id, eg);
    d_act  = resp_data;
    eq_act = resp_eq;
    nz = noisy ? N'($urandom) : '0;
    nz[eg] = 1'b0;
    resp_ready = nz;
    repeat (stall) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_resp_valid", resp_valid, onehot(eg));
      check("stall_resp_data", resp_data, ed);
      check("stall_resp_id", resp_id, eg);
      check("stall_req_ready", req_ready, 0);
    end
    resp_ready[eg] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = '0;
    @(negedge clk);
    check("done_busy", busy, 0);
    check("done_resp_valid", resp_valid, 0);
    check("hold_alu_con", alu_con, op_m[eg]);
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] vmask;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    int           stall;
    int           exp_g;
    logic [W-1:0] exp_d;
    logic         exp_eq;
  } vec_t;

  vec_t         tab[10];
  int           g;
  logic [W-1:0] d;
  logic         e;
  logic [N-1:0] vm;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
`ifdef ALU_ARB_LOCK_EN
    req_lock = '0;
`endif

    tab[0] = '{1'b1, 4'b0010, 32'd5,  32'd3,  4'd0, 0, 1, 32'd8, 1'b0};
    tab[1] = '{1'b1, 4'b1111, 32'd10, 32'd10, 4'd1, 0, 0, 32'd0, 1'b1};
    tab[2] = '{1'b0, 4'b1111, 32'd10, 32'd10, 4'd1, 0, 1, 32'd0, 1'b1};
    tab[3] = '{1'b0, 4'b1111, 32'd10, 32'd10, 4'd1, 0, 2, 32'd0, 1'b1};
    tab[4] = '{1'b0, 4'b1111, 32'd10, 32'd10, 4'd1, 0, 3, 32'd0, 1'b1};
    tab[5] = '{1'b0, 4'b1111, 32'd10, 32'd10, 4'd1, 0, 0, 32'd0, 1'b1};
    tab[6] = '{1'b0, 4'b0100, 32'hFFFF0000, 32'h0F0F0F0F, 4'd4, 5, 2, 32'hF0F00F0F, 1'b0};
    tab[7] = '{1'b0, 4'b0001, 32'd1,  32'd4,  4'd5, 0, 0, 32'd16, 1'b0};
    tab[8] = '{1'b0, 4'b1111, 32'd1,  32'd2,  4'd0, 0, 1, 32'd3, 1'b0};
    tab[9] = '{1'b0, 4'b1000, 32'd7,  32'd7,  4'b1001, 0, 3, 32'd0, 1'b1};

    do_reset();
    idle_cycles(2);

    for (int t = 0; t < 10; t++) begin
      if (tab[t].rst) do_reset();
      for (int i = 0; i < N; i++) begin
        a_m[i] = tab[t].a;
        b_m[i] = tab[t].b;
        op_m[i] = tab[t].op;
      end
      drive_ops();
      run_txn(tab[t].vmask, 1'b1, tab[t].stall, 1'b0, g, d, e);
      check("tab_grant", g, tab[t].exp_g);
      check("tab_data", d, tab[t].exp_d);
      check("tab_eq", e, tab[t].exp_eq);
    end

    // reset while EXEC: the op is dropped and never answered
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_m[i] = 32'd100;
      b_m[i] = 32'd1;
      op_m[i] = 4'd3;
    end
    drive_ops();
    req_valid = 4'b0100;
    #1;
    check("mid_grant", req_ready, 4'b0100);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    check("mid_exec_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_resp_valid", resp_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_alu_con", alu_con, 0);
    check("mid_alu_in1", alu_in1, 0);
    check("mid_resp_id", resp_id, 0);
    reset = 1'b0;
    rr_m = 0;
    idle_cycles(4);
    run_txn(4'b1111, 1'b1, 0, 1'b0, g, d, e);
    check("mid_rr_restart", g, 0);

`ifdef ALU_ARB_LOCK_EN
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_m[i] = $urandom;
      b_m[i] = $urandom;
      op_m[i] = 4'd0;
    end
    drive_ops();
    req_lock = 4'b0001;
    run_txn(4'b0101, 1'b1, 0, 1'b0, g, d, e);
    check("lock_grant0", g, 0);
    run_txn(4'b0101, 1'b1, 0, 1'b0, g, d, e);
    check("lock_grant1", g, 0);
    req_lock = 4'b0000;
    run_txn(4'b0101, 1'b1, 0, 1'b0, g, d, e);
    check("lock_grant2", g, 0);
    run_txn(4'b0101, 1'b1, 0, 1'b0, g, d, e);
    check("lock_release", g, 2);
    req_lock = 4'b0001;
    run_txn(4'b0001, 1'b1, 0, 1'b0, g, d, e);
    check("lock_solo", g, 0);
    run_txn(4'b0100, 1'b1, 0, 1'b0, g, d, e);
    check("lock_resume", g, 2);
    req_lock = '0;
`endif

    do_reset();
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        a_m[i] = $urandom;
        b_m[i] = ($urandom_range(0, 3) == 0) ? a_m[i] : $urandom;
        op_m[i] = 4'($urandom_range(0, 15));
      end
      drive_ops();
      if ($urandom_range(0, 4) == 0) idle_cycles(1);
`ifdef ALU_ARB_LOCK_EN
      req_lock = N'($urandom);
`endif
      vm = N'($urandom_range(1, (1 << N) - 1));
      run_txn(vm, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1, g, d, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
